// File: rtl/spi_master_sequencer.sv
// Sequences SPI master register accesses (init, select, shift, poll, read, deselect)
// on behalf of two round-robin arbitrated requesters.
module spi_master_sequencer #(
  parameter logic [3:0]  CPRE    = 4'd2,
  parameter logic        CPOL    = 1'b0,
  parameter logic        CPHA    = 1'b0,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [2:0]  req_ss0,
  input  logic [2:0]  req_ss1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  m_addr,
  output logic        m_wr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  // SPI master register map (same encoding as spi_defines.vh)
  localparam logic [1:0] SPI_CONFIG = 2'd0;
  localparam logic [1:0] SPI_CTRL   = 2'd1;
  localparam logic [1:0] SPI_SSELEC = 2'd2;
  localparam logic [1:0] SPI_BUFFER = 2'd3;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DW    = 32;

  typedef enum logic [3:0] {
    S_INIT_CFG,
    S_INIT_EN,
    S_IDLE,
    S_SEL,
    S_LOAD,
    S_SETTLE,
    S_POLL,
    S_READ,
    S_DESEL,
    S_RESP
  } state_t;

  state_t           state, state_d;
  logic             owner;
  logic             rr_ptr;
  logic [DW-1:0]    data_q;
  logic [2:0]       ss_q;
  logic [CNT_W-1:0] poll_cnt;

  logic             grant;
  logic             handshake;
  logic             spi_busy;
  logic             timeout_c;
  logic             m_wr_c;
  logic [1:0]       m_addr_c;
  logic [DW-1:0]    m_wdata_c;

  // Single valid requester wins; on contention the pointer picks the one not served last
  always_comb begin
    grant = rr_ptr;
    if (req_valid == 2'b01) grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;
  end

  assign req_ready = (state == S_IDLE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign handshake = |(req_valid & req_ready);
  assign rsp_valid = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != S_IDLE);
  assign spi_busy  = m_rdata[7];
  assign timeout_c = (state == S_POLL) && spi_busy
                     && (poll_cnt == CNT_W'(TIMEOUT - 1));

  // Bus outputs are forced idle while reset is asserted, even though the state is INIT_CFG
  assign m_wr    = rst ? 1'b0     : m_wr_c;
  assign m_addr  = rst ? SPI_CTRL : m_addr_c;
  assign m_wdata = rst ? '0       : m_wdata_c;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state <= S_INIT_CFG;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    m_wr_c    = 1'b0;
    m_addr_c  = SPI_CTRL;
    m_wdata_c = '0;
    case (state)
      S_INIT_CFG: begin
        m_wr_c    = 1'b1;
        m_addr_c  = SPI_CONFIG;
        m_wdata_c = {24'h0, 2'b00, CPOL, CPHA, CPRE};
        state_d   = S_INIT_EN;
      end
      S_INIT_EN: begin
        m_wr_c    = 1'b1;
        m_addr_c  = SPI_CTRL;
        m_wdata_c = 32'h0000_0001;
        state_d   = S_IDLE;
      end
      S_IDLE: begin
        if (handshake) state_d = S_SEL;
      end
      S_SEL: begin
        m_wr_c    = 1'b1;
        m_addr_c  = SPI_SSELEC;
        m_wdata_c = {24'h0, ~(8'h01 << ss_q)};
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        m_wr_c    = 1'b1;
        m_addr_c  = SPI_BUFFER;
        m_wdata_c = data_q;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_POLL;
      end
      S_POLL: begin
        if (!spi_busy)      state_d = S_READ;
        else if (timeout_c) state_d = S_DESEL;
      end
      S_READ: begin
        m_addr_c = SPI_BUFFER;
        state_d  = S_DESEL;
      end
      S_DESEL: begin
        m_wr_c    = 1'b1;
        m_addr_c  = SPI_SSELEC;
        m_wdata_c = 32'h0000_00FF;
        state_d   = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_INIT_CFG;
    endcase
  end

  // Request capture, arbitration pointer, poll counter and response registers
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      data_q   <= '0;
      ss_q     <= '0;
      poll_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (handshake) begin
        owner  <= grant;
        rr_ptr <= ~grant;
        data_q <= grant ? req_data1 : req_data0;
        ss_q   <= grant ? req_ss1 : req_ss0;
      end
      if (state == S_SETTLE) begin
        poll_cnt <= '0;
      end else if ((state == S_POLL) && spi_busy && !timeout_c) begin
        poll_cnt <= poll_cnt + CNT_W'(1);
      end
      if (state == S_READ) begin
        rsp_data <= m_rdata;
        rsp_err  <= 1'b0;
      end else if (timeout_c) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_master_sequencer.md
SPI_MASTER_SEQUENCER -- requirements
Module: spi_master_sequencer

Interface
REQ-001 Parameter: CPRE, 4'd2, SCK prescaler written to the SPI master config register.
REQ-002 Parameter: CPOL, 1'b0, clock polarity config bit.
REQ-003 Parameter: CPHA, 1'b0, clock phase config bit.
REQ-004 Parameter: TIMEOUT, 50000, maximum busy-poll cycles per transfer (1..65535).
REQ-005 Ports: i_clk  in  1  single clock, all logic on its rising edge; rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: req_valid  in  2  per-requester transfer request; req_ready  out  2  per-requester accept (combinational).
REQ-007 Ports: req_data0, req_data1  in  32  TX word per requester; req_ss0, req_ss1  in  3  slave-select index per requester.
REQ-008 Ports: rsp_valid  out  2  one-cycle response strobe to the owning requester; rsp_data  out  32  RX word; rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-009 Ports: m_addr  out  2  SPI master register address (`SPI_CONFIG/`SPI_CTRL/`SPI_SSELEC/`SPI_BUFFER from spi_defines.vh); m_wr  out  1  write strobe; m_wdata  out  32  write data; m_rdata  in  32  read data for m_addr.
REQ-010 Ports: busy  out  1  high in every state except IDLE.

Function
REQ-011 The FSM states SHALL be INIT_CFG, INIT_EN, IDLE, SEL, LOAD, SETTLE, POLL, READ, DESEL, RESP; each non-POLL state lasts exactly one cycle.
REQ-012 INIT_CFG: m_wr=1, m_addr=`SPI_CONFIG, m_wdata={24'h0,2'b00,CPOL,CPHA,CPRE}; next INIT_EN.
REQ-013 INIT_EN: m_wr=1, m_addr=`SPI_CTRL, m_wdata=32'h01; next IDLE.
REQ-014 IDLE: req_ready asserts only for the granted requester; handshake = valid&ready same cycle; on handshake latch data, ss, owner index; next SEL.
REQ-015 Arbitration SHALL be two-way round-robin: single valid wins; both valid -> requester not granted last; pointer updates on each handshake; reset favours requester 0.
REQ-016 Requesters SHALL hold req_valid, data, ss stable until handshake; req_ready=0 outside IDLE.
REQ-017 SEL: m_wr=1, m_addr=`SPI_SSELEC, m_wdata={24'h0,~(8'h01<<ss)}.
REQ-018 LOAD: m_wr=1, m_addr=`SPI_BUFFER, m_wdata=latched data (starts shift).
REQ-019 SETTLE: m_wr=0, m_addr=`SPI_CTRL; poll counter cleared; next POLL unconditionally.
REQ-020 POLL: m_addr=`SPI_CTRL; m_rdata[7]==0 -> READ; else counter+1; counter reaching TIMEOUT -> DESEL with error latched, rsp_data=0.
REQ-021 READ: m_addr=`SPI_BUFFER; m_rdata registered into rsp_data at end of cycle.
REQ-022 DESEL: m_wr=1, m_addr=`SPI_SSELEC, m_wdata=32'hFF.
REQ-023 RESP: rsp_valid[owner]=1 for exactly one cycle with rsp_data and rsp_err; next IDLE.
REQ-024 Latency: handshake at cycle T, busy clear seen on n-th POLL cycle (n>=1) -> rsp_valid at T+6+n.
REQ-025 m_wr SHALL be 0 in IDLE, SETTLE, POLL, READ, RESP; m_wdata don't-care when m_wr=0.
REQ-026 rsp_data, rsp_err SHALL hold their values until the next RESP.

Reset
REQ-027 rst=1 SHALL immediately force state INIT_CFG, m_wr=0, m_addr=`SPI_CTRL, m_wdata=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=1, RR pointer to requester 0, poll counter 0.
REQ-028 Reset mid-transfer SHALL discard the transfer with no rsp_valid; init sequence replays after release.
REQ-029 First init write occurs on the first rising edge with rst=0.

Verification
REQ-030 Reset release -> CONFIG write 32'h02, next cycle CTRL write 32'h01, then busy=0, idle.
REQ-031 req0 data 32'h00000003 ss=0, model busy 3 cycles, buffer 32'hA5A50003 -> SSELEC 32'hFE, BUFFER 32'h3, rsp_valid=2'b01 at T+9, rsp_data=32'hA5A50003, rsp_err=0, SSELEC 32'hFF.
REQ-032 Both valid held continuously for 4 transfers -> grant order 0,1,0,1; req1 ss=7 -> SSELEC 32'h7F.
REQ-033 TIMEOUT=16, busy stuck high -> after 16 POLL cycles DESEL 32'hFF, rsp_err=1, rsp_data=0.
REQ-034 rst pulsed during POLL -> outputs at reset values same cycle, no rsp_valid, CONFIG/CTRL writes repeat.
